// File: rtl/multi_start_bit_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_start_bit_det_pkg
// Description : Shared state encoding and counter sizing for the start-bit
//               detector.
// Revision    : 1.0 - initial release
// ============================================================================
package multi_start_bit_det_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        QUAL      = 2'd1,
        BUSY      = 2'd2,
        WAIT_HIGH = 2'd3
    } state_e;

    // Wide enough to hold FILTER_LEN; never narrower than one bit.
    function automatic int cnt_width(input int filter_len);
        int w;
        w = $clog2(filter_len + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : multi_start_bit_det_pkg
`default_nettype wire

// File: rtl/start_bit_det_ch.sv
`default_nettype none
// ============================================================================
// Module      : start_bit_det_ch
// Description : One channel: synchroniser chain, low-width qualifier and
//               lockout state machine with registered pulse outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module start_bit_det_ch
    import multi_start_bit_det_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_serial,
    input  logic i_en,
    input  logic i_packet_done,
    output logic o_start,
    output logic o_false_start,
    output logic o_busy
);

    localparam int                 c_CNT_W    = cnt_width(FILTER_LEN);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    state_e                 r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_start;
    logic                   r_false_start;
    logic                   r_busy;

    // Idle level is high, so the chain resets to 1 and never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_serial};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_start       <= 1'b0;
            r_false_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_start       <= 1'b0;
            r_false_start <= 1'b0;
            if (!i_en) begin
                r_state <= WAIT_HIGH;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!w_s) begin
                            if (FILTER_LEN == 1) begin
                                r_start <= 1'b1;
                                r_busy  <= 1'b1;
                                r_state <= BUSY;
                            end else begin
                                r_cnt   <= c_CNT_ONE;
                                r_state <= QUAL;
                            end
                        end
                    end
                    QUAL: begin
                        if (w_s) begin
                            r_false_start <= 1'b1;
                            r_cnt         <= '0;
                            r_state       <= IDLE;
                        end else if (r_cnt == c_CNT_LAST) begin
                            r_start <= 1'b1;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= BUSY;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_ONE;
                        end
                    end
                    BUSY: begin
                        if (i_packet_done) begin
                            r_busy  <= 1'b0;
                            r_state <= w_s ? IDLE : WAIT_HIGH;
                        end
                    end
                    WAIT_HIGH: begin
                        // A break or stuck-low line must return high before re-arming.
                        if (w_s) begin
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_start       = r_start;
    assign o_false_start = r_false_start;
    assign o_busy        = r_busy;

endmodule : start_bit_det_ch
`default_nettype wire

// File: rtl/multi_start_bit_det.sv
`default_nettype none
// ============================================================================
// Module      : multi_start_bit_det
// Description : NUM_CH independent UART start-bit detectors.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_start_bit_det
    import multi_start_bit_det_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] serial_in,
    input  logic [NUM_CH-1:0] en,
    input  logic [NUM_CH-1:0] packet_done,
    output logic [NUM_CH-1:0] new_packet_detected,
    output logic [NUM_CH-1:0] false_start,
    output logic [NUM_CH-1:0] busy
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        start_bit_det_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .i_serial      (serial_in[g]),
            .i_en          (en[g]),
            .i_packet_done (packet_done[g]),
            .o_start       (new_packet_detected[g]),
            .o_false_start (false_start[g]),
            .o_busy        (busy[g])
        );
    end

endmodule : multi_start_bit_det
`default_nettype wire

// File: tb/tb_multi_start_bit_det.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_start_bit_det
// Description : Bench for two detector instances (FILTER_LEN 1 and 4) sharing
//               stimulus, checked against a run-length behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_start_bit_det;

    localparam int c_NCH = 4;
    localparam int c_SS  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [c_NCH-1:0] serial_in;
    logic [c_NCH-1:0] en;
    logic [c_NCH-1:0] packet_done;
    logic [c_NCH-1:0] a_npd, a_fs, a_busy;
    logic [c_NCH-1:0] b_npd, b_fs, b_busy;

    int compared   = 0;
    int mismatched = 0;

    multi_start_bit_det #(.NUM_CH(c_NCH), .SYNC_STAGES(c_SS), .FILTER_LEN(1)) dut_a (
        .clk(clk), .rst(rst), .serial_in(serial_in), .en(en), .packet_done(packet_done),
        .new_packet_detected(a_npd), .false_start(a_fs), .busy(a_busy)
    );

    multi_start_bit_det #(.NUM_CH(c_NCH), .SYNC_STAGES(c_SS), .FILTER_LEN(4)) dut_b (
        .clk(clk), .rst(rst), .serial_in(serial_in), .en(en), .packet_done(packet_done),
        .new_packet_detected(b_npd), .false_start(b_fs), .busy(b_busy)
    );

    always #5 clk = ~clk;

    // Model: per channel, length of the current qualified low run, whether the
    // channel is locked by an accepted frame, and whether it needs a high first.
    logic [c_SS-1:0]  m_sync [c_NCH];
    int               m_run       [2][c_NCH];
    bit               m_locked    [2][c_NCH];
    bit               m_need_high [2][c_NCH];
    logic [c_NCH-1:0] exp_npd [2];
    logic [c_NCH-1:0] exp_fs  [2];
    logic [c_NCH-1:0] exp_busy[2];

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int fl;
            fl = (d == 0) ? 1 : 4;
            exp_npd[d] = '0;
            exp_fs[d]  = '0;
            for (int ch = 0; ch < c_NCH; ch++) begin
                logic s;
                s = m_sync[ch][c_SS-1];
                if (rst) begin
                    m_run[d][ch] = 0; m_locked[d][ch] = 0; m_need_high[d][ch] = 0;
                end else if (!en[ch]) begin
                    m_run[d][ch] = 0; m_locked[d][ch] = 0; m_need_high[d][ch] = 1;
                end else if (m_locked[d][ch]) begin
                    if (packet_done[ch]) begin
                        m_locked[d][ch]    = 0;
                        m_need_high[d][ch] = !s;
                    end
                end else if (m_need_high[d][ch]) begin
                    if (s) m_need_high[d][ch] = 0;
                end else if (!s) begin
                    m_run[d][ch]++;
                    if (m_run[d][ch] == fl) begin
                        exp_npd[d][ch]  = 1'b1;
                        m_locked[d][ch] = 1;
                        m_run[d][ch]    = 0;
                    end
                end else begin
                    if (m_run[d][ch] > 0) exp_fs[d][ch] = 1'b1;
                    m_run[d][ch] = 0;
                end
                exp_busy[d][ch] = m_locked[d][ch];
            end
        end
        for (int ch = 0; ch < c_NCH; ch++) begin
            if (rst) m_sync[ch] = '1;
            else     m_sync[ch] = {m_sync[ch][c_SS-2:0], serial_in[ch]};
        end
    endtask

    task automatic check();
        compared++;
        assert (a_npd === exp_npd[0]) else begin
            mismatched++; $error("FAIL npd_fl1 observed=%b expected=%b t=%0t", a_npd, exp_npd[0], $time);
        end
        compared++;
        assert (a_fs === exp_fs[0]) else begin
            mismatched++; $error("FAIL fs_fl1 observed=%b expected=%b t=%0t", a_fs, exp_fs[0], $time);
        end
        compared++;
        assert (a_busy === exp_busy[0]) else begin
            mismatched++; $error("FAIL busy_fl1 observed=%b expected=%b t=%0t", a_busy, exp_busy[0], $time);
        end
        compared++;
        assert (b_npd === exp_npd[1]) else begin
            mismatched++; $error("FAIL npd_fl4 observed=%b expected=%b t=%0t", b_npd, exp_npd[1], $time);
        end
        compared++;
        assert (b_fs === exp_fs[1]) else begin
            mismatched++; $error("FAIL fs_fl4 observed=%b expected=%b t=%0t", b_fs, exp_fs[1], $time);
        end
        compared++;
        assert (b_busy === exp_busy[1]) else begin
            mismatched++; $error("FAIL busy_fl4 observed=%b expected=%b t=%0t", b_busy, exp_busy[1], $time);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic drive(input logic [c_NCH-1:0] si, input logic [c_NCH-1:0] e,
                         input logic [c_NCH-1:0] pd, input int n);
        serial_in   = si;
        en          = e;
        packet_done = pd;
        repeat (n) step();
        packet_done = '0;
    endtask

    initial begin
        for (int ch = 0; ch < c_NCH; ch++) begin
            m_sync[ch] = '1;
            for (int d = 0; d < 2; d++) begin
                m_run[d][ch] = 0; m_locked[d][ch] = 0; m_need_high[d][ch] = 0;
            end
        end
        rst = 1'b1; serial_in = '1; en = '1; packet_done = '0;
        step(); step();
        rst = 1'b0;
        drive(4'b1111, 4'b1111, 4'b0000, 2);

        // ch0 falls and holds: nominal latency and lockout
        drive(4'b1110, 4'b1111, 4'b0000, 8);
        drive(4'b1111, 4'b1111, 4'b0000, 3);
        drive(4'b1111, 4'b1111, 4'b0001, 1);
        drive(4'b1111, 4'b1111, 4'b0000, 3);

        // ch1 short glitch, then a qualified low
        drive(4'b1101, 4'b1111, 4'b0000, 2);
        drive(4'b1111, 4'b1111, 4'b0000, 5);
        drive(4'b1101, 4'b1111, 4'b0000, 8);

        // ch1 busy: toggling ignored, packet_done while low, then re-arm
        for (int i = 0; i < 6; i++) drive((i % 2) ? 4'b1111 : 4'b1101, 4'b1111, 4'b0000, 2);
        drive(4'b1101, 4'b1111, 4'b0000, 3);
        drive(4'b1101, 4'b1111, 4'b0010, 1);
        drive(4'b1101, 4'b1111, 4'b0000, 6);
        drive(4'b1111, 4'b1111, 4'b0000, 3);
        drive(4'b1101, 4'b1111, 4'b0000, 8);
        drive(4'b1111, 4'b1111, 4'b0010, 1);
        drive(4'b1111, 4'b1111, 4'b0000, 3);

        // ch2 disabled mid-qualification, re-enabled while low
        drive(4'b1011, 4'b1111, 4'b0000, 3);
        drive(4'b1011, 4'b1011, 4'b0000, 4);
        drive(4'b1011, 4'b1111, 4'b0000, 8);
        drive(4'b1111, 4'b1111, 4'b0000, 3);
        drive(4'b1011, 4'b1111, 4'b0000, 8);
        drive(4'b1111, 4'b1111, 4'b0100, 1);
        drive(4'b1111, 4'b1111, 4'b0000, 3);

        // all channels fall together, release ch3 only
        drive(4'b0000, 4'b1111, 4'b0000, 8);
        drive(4'b1111, 4'b1111, 4'b1000, 1);
        drive(4'b1111, 4'b1111, 4'b0000, 2);
        drive(4'b1111, 4'b1111, 4'b0111, 1);
        drive(4'b1111, 4'b1111, 4'b0000, 3);

        // reset during qualification and during busy
        drive(4'b1110, 4'b1111, 4'b0000, 4);
        rst = 1'b1; step(); rst = 1'b0;
        drive(4'b1111, 4'b1111, 4'b0000, 3);
        drive(4'b1110, 4'b1111, 4'b0000, 8);
        rst = 1'b1; step(); rst = 1'b0;
        drive(4'b1111, 4'b1111, 4'b0000, 3);
        drive(4'b1110, 4'b1111, 4'b0000, 8);
        drive(4'b1111, 4'b1111, 4'b0001, 1);
        drive(4'b1111, 4'b1111, 4'b0000, 3);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [c_NCH-1:0] si, e, pd;
            si = serial_in; e = en; pd = '0;
            for (int ch = 0; ch < c_NCH; ch++) begin
                if ($urandom_range(0, 4) == 0) si[ch] = ~si[ch];
                if (e[ch]) begin
                    if ($urandom_range(0, 79) == 0) e[ch] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    e[ch] = 1'b1;
                end
                if ($urandom_range(0, 11) == 0) pd[ch] = 1'b1;
            end
            rst = ($urandom_range(0, 499) == 0);
            drive(si, e, pd, 1);
            rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_multi_start_bit_det
`default_nettype wire

// File: doc/multi_start_bit_det.md
# multi_start_bit_det

Parametrised, multi-channel start-bit detector for the UART receive path. Each of NUM_CH serial lines is synchronised through a configurable flop chain, and a falling edge is qualified by a minimum low-width filter. Every channel emits a one-cycle start pulse or a false-start pulse, then stays locked out until the downstream receiver reports packet completion and the line returns idle. It sits between the pads and the per-channel receiver timers/shift registers.

## Interface
- NUM_CH, 4, number of independent serial channels (≥1)
- SYNC_STAGES, 2, synchroniser depth per channel (≥2)
- FILTER_LEN, 1, consecutive low samples required to accept a start bit (≥1)

- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- serial_in  input  NUM_CH  asynchronous serial lines, idle high
- en  input  NUM_CH  per-channel detector enable
- packet_done  input  NUM_CH  one-cycle pulse from the receiver that the frame ended
- new_packet_detected  output  NUM_CH  one-cycle pulse: start bit accepted
- false_start  output  NUM_CH  one-cycle pulse: low glitch shorter than FILTER_LEN rejected
- busy  output  NUM_CH  channel locked out (state BUSY)

## Operation
- Sync chain per channel: SYNC_STAGES flops, all reset to 1; s = last stage. The chain runs regardless of en.
- Per-channel FSM states: IDLE, QUAL, BUSY, WAIT_HIGH. Reset state is IDLE, with cnt = 0.
- IDLE:
  - s==0 and FILTER_LEN==1: pulse new_packet_detected, go to BUSY.
  - s==0 and FILTER_LEN>1: set cnt=1, go to QUAL.
- QUAL:
  - s==1: pulse false_start, go to IDLE.
  - s==0 and cnt==FILTER_LEN-1: pulse new_packet_detected, go to BUSY.
  - Otherwise increment cnt.
- BUSY: on packet_done, go to IDLE if s==1 this cycle, else go to WAIT_HIGH. Ignore s otherwise.
- WAIT_HIGH: go to IDLE on the first s==1 sample. This prevents re-triggering on a break or stuck-low line.
- en[ch]==0 takes priority over every transition:
  - Next state is WAIT_HIGH and cnt is cleared.
  - No pulses are generated. An aborted QUAL gives no false_start.
  - On re-enable, the channel re-arms only after the line is seen high.
- packet_done is ignored outside BUSY.
- cnt width is $clog2(FILTER_LEN+1) and it never wraps; the maximum value reached is FILTER_LEN-1.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.

## Timing
- All outputs are registered. Reset values: new_packet_detected=0, false_start=0, busy=0.
- Latency: serial_in low before edge 1 and held gives new_packet_detected high during the cycle after edge SYNC_STAGES+FILTER_LEN. With defaults, the pulse is high after edge 3.
- Pulses last exactly one cycle. new_packet_detected and false_start are never high together on the same channel.
- busy rises with new_packet_detected and falls the cycle after packet_done is sampled.
- A low glitch of L<FILTER_LEN synced samples gives false_start one cycle after the first high sample following it.
- rst asserted mid-operation:
  - All states return to IDLE, sync flops to 1, outputs to 0 on the next edge.
  - Any in-flight qualification is dropped silently.

## Structure
- Package multi_start_bit_det_pkg holds the state enum typedef (IDLE, QUAL, BUSY, WAIT_HIGH) and a function giving the counter width from FILTER_LEN.
- Sub-module start_bit_det_ch contains the per-channel sync chain, FSM and counter, parametrised by SYNC_STAGES and FILTER_LEN. The top generates NUM_CH instances.

## Test plan
- Defaults, ch0 driven low at edge 1 and held → new_packet_detected[0] high for exactly 1 cycle after edge 3, busy[0] high from then; other channels silent.
- FILTER_LEN=4, ch1 low for 2 synced samples then high → false_start[1] one cycle pulse, no new_packet_detected; then low for 4 samples → start pulse after edge SYNC_STAGES+4.
- Channel in BUSY, line toggles low/high repeatedly → no pulses. packet_done while s==0 → WAIT_HIGH, no re-trigger until the line goes high then low again.
- en[2] dropped mid-QUAL → no false_start, no start pulse. en[2] raised while line low → no detection until the line goes high and then falls.
- All 4 channels fall on the same edge → all new_packet_detected bits high in the same cycle; packet_done on ch3 only → busy=4'b0111 next cycle.
- rst asserted during QUAL and during BUSY → all outputs 0 the next cycle. After release with the line high, a fresh falling edge is detected with nominal latency.
